// File: rtl/ecc_76_enc_fault_detc_pkg.sv
// ----------------------------------------------------------------------------
// ecc_76_enc_fault_detc_pkg
// Shared definitions for the lockstep SECDED encoder:
//   - default widths (data, check bits, fault counter)
//   - error-injection mode encodings
//   - injection FSM state encoding
//   - hamming_pos(): codeword position of a data bit in the Hamming layout
// ----------------------------------------------------------------------------
package ecc_76_enc_fault_detc_pkg;

    localparam int DATA_WIDTH_DEF   = 76;
    localparam int PARITY_WIDTH_DEF = 8;   // 7 Hamming bits + 1 overall parity
    localparam int CNT_WIDTH_DEF    = 8;

    typedef enum logic [1:0] {
        INJ_NONE   = 2'b00,
        INJ_SINGLE = 2'b01,   // flip data bit 0
        INJ_DOUBLE = 2'b10,   // flip data bits 0 and 1
        INJ_RSVD   = 2'b11    // behaves like INJ_NONE
    } inj_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } inj_state_e;

    // Codeword layout shared with the ecc_76_cal decoder: positions are
    // numbered from 1, check bit k sits at position 2**k, and data bits fill
    // the remaining positions in ascending order (data bit 0 -> position 3).
    // Only evaluated at elaboration time.
    function automatic int unsigned hamming_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 3; p < 256; p++) begin
            if ((p & (p - 1)) != 0) begin
                if ((cnt == idx) && (pos == 0)) begin
                    pos = p;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_76_enc.sv
// ----------------------------------------------------------------------------
// ecc_76_enc
// Combinational SECDED check-bit generator.
// Ports:
//   data_i    [DATA_WIDTH]   data word to protect
//   bypass_i                 1 -> parity_o forced to zero
//   parity_o  [PARITY_WIDTH] {overall parity, Hamming bits [PARITY_WIDTH-2:0]}
// Hamming bit k is the XOR of all data bits whose codeword position has bit k
// set; the overall bit makes the XOR over data + Hamming bits even.
// ----------------------------------------------------------------------------
module ecc_76_enc
    import ecc_76_enc_fault_detc_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PARITY_WIDTH = PARITY_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    bypass_i,
    output logic [PARITY_WIDTH-1:0] parity_o
);

    localparam int HW = PARITY_WIDTH - 1;

    logic [HW-1:0] contrib [DATA_WIDTH];
    logic [HW-1:0] ham;

    // Each set data bit contributes its codeword position to the syndrome.
    for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_pos
        localparam int unsigned POS = hamming_pos(d);
        localparam logic [HW-1:0] POS_V = HW'(POS);
        assign contrib[d] = data_i[d] ? POS_V : '0;
    end

    always_comb begin
        ham = '0;
        for (int d = 0; d < DATA_WIDTH; d++) begin
            ham = ham ^ contrib[d];
        end
        parity_o = '0;
        if (!bypass_i) begin
            parity_o = {(^data_i) ^ (^ham), ham};
        end
    end

endmodule

// File: rtl/ecc_76_enc_fault_detc.sv
// ----------------------------------------------------------------------------
// ecc_76_enc_fault_detc
// Registered SECDED encoder with lockstep fault detection and one-shot error
// injection.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data   upstream beat
//   m_valid/m_ready          downstream handshake
//   m_data                   data (possibly with injected flips)
//   m_parity                 check bits from encoder instance 0
//   m_ecc_fault              lockstep mismatch seen when this beat was accepted
//   bypass                   zero the check bits
//   ecc_fault_detc_en        enable lockstep comparison
//   fault_sticky, fault_cnt  fault status (sticky flag, saturating count)
//   fault_clr                clear fault status
//   inj_arm, inj_mode        arm one-shot injection with the given mode
//   inj_armed, inj_done      injection pending / applied pulse
// ----------------------------------------------------------------------------
module ecc_76_enc_fault_detc
    import ecc_76_enc_fault_detc_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PARITY_WIDTH = PARITY_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [PARITY_WIDTH-1:0] m_parity,
    output logic                    m_ecc_fault,
    input  logic                    bypass,
    input  logic                    ecc_fault_detc_en,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    input  logic                    fault_clr,
    input  logic                    inj_arm,
    input  logic [1:0]              inj_mode,
    output logic                    inj_armed,
    output logic                    inj_done
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Handshake: a beat transfers on any rising edge where valid & ready are
    // both high; valid never waits on ready, and m_* stays frozen while
    // m_valid & ~m_ready. The output stage is one register deep and refills
    // in the same cycle it drains, so s_ready = ~m_valid | m_ready.

    // ---------------- lockstep encoders ----------------
    (* keep = "true", dont_touch = "true" *) logic [PARITY_WIDTH-1:0] enc0_parity;
    (* keep = "true", dont_touch = "true" *) logic [PARITY_WIDTH-1:0] enc1_parity;

    (* keep = "true", dont_touch = "true" *)
    ecc_76_enc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_WIDTH(PARITY_WIDTH)
    ) u_enc0 (
        .data_i  (s_data),
        .bypass_i(bypass),
        .parity_o(enc0_parity)
    );

    (* keep = "true", dont_touch = "true" *)
    ecc_76_enc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_WIDTH(PARITY_WIDTH)
    ) u_enc1 (
        .data_i  (s_data),
        .bypass_i(bypass),
        .parity_o(enc1_parity)
    );

    // ---------------- state ----------------
    logic                    m_valid_q,    m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q,     m_data_d;
    logic [PARITY_WIDTH-1:0] m_parity_q,   m_parity_d;
    logic                    m_fault_q,    m_fault_d;
    logic                    sticky_q,     sticky_d;
    logic [CNT_WIDTH-1:0]    cnt_q,        cnt_d;
    logic                    inj_done_q,   inj_done_d;
    inj_state_e              state_q,      state_d;
    logic [1:0]              inj_mode_q,   inj_mode_d;

    logic                    accept;
    logic                    mismatch;
    logic                    fault_now;
    logic [CNT_WIDTH-1:0]    cnt_base;
    logic [DATA_WIDTH-1:0]   inj_mask;

    assign s_ready     = ~m_valid_q | m_ready;
    assign accept      = s_valid & s_ready;
    assign mismatch    = (enc0_parity != enc1_parity);
    assign fault_now   = accept & ecc_fault_detc_en & mismatch;

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_parity     = m_parity_q;
    assign m_ecc_fault  = m_fault_q;
    assign fault_sticky = sticky_q;
    assign fault_cnt    = cnt_q;
    assign inj_done     = inj_done_q;

    // ---------------- injection FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            inj_mode_q <= INJ_NONE;
        end else begin
            state_q    <= state_d;
            inj_mode_q <= inj_mode_d;
        end
    end

    // ---------------- injection FSM: next state ----------------
    // The mode is captured at arm time so later inj_mode changes do not
    // affect a pending injection.
    always_comb begin
        state_d    = state_q;
        inj_mode_d = inj_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (inj_arm && ((inj_mode == INJ_SINGLE) || (inj_mode == INJ_DOUBLE))) begin
                    state_d    = ST_ARMED;
                    inj_mode_d = inj_mode;
                end
            end
            ST_ARMED: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- injection FSM: outputs ----------------
    always_comb begin
        inj_armed = (state_q == ST_ARMED);
        inj_mask  = '0;
        if (state_q == ST_ARMED) begin
            inj_mask = (inj_mode_q == INJ_DOUBLE) ? DATA_WIDTH'(3) : DATA_WIDTH'(1);
        end
    end

    // ---------------- datapath / fault status next state ----------------
    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_parity_d = m_parity_q;
        m_fault_d  = m_fault_q;
        inj_done_d = accept & inj_armed;

        if (accept) begin
            m_valid_d  = 1'b1;
            // Parity is taken from the clean data; only m_data sees the flip.
            m_data_d   = s_data ^ inj_mask;
            m_parity_d = enc0_parity;
            m_fault_d  = fault_now;
        end else if (m_ready) begin
            m_valid_d  = 1'b0;
        end

        // Clear beats a simultaneous fault for the sticky flag, while the
        // counter clears first and then still counts the coincident fault.
        sticky_d = sticky_q;
        if (fault_clr) begin
            sticky_d = 1'b0;
        end else if (fault_now) begin
            sticky_d = 1'b1;
        end

        cnt_base = fault_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (fault_now && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_fault_q  <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            inj_done_q <= 1'b0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_fault_q  <= m_fault_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
            inj_done_q <= inj_done_d;
        end
    end

    // Payload registers carry no reset; m_valid qualifies them.
    always_ff @(posedge clk) begin
        m_data_q   <= m_data_d;
        m_parity_q <= m_parity_d;
    end

endmodule

// File: tb/tb_ecc_76_enc_fault_detc.sv
// ----------------------------------------------------------------------------
// tb_ecc_76_enc_fault_detc
// Self-checking bench: behavioural reference model (syndrome arithmetic over
// codeword positions plus an accepted-beat queue), a per-cycle compare
// process, directed literal expectations and a randomized phase.
// ----------------------------------------------------------------------------
module tb_ecc_76_enc_fault_detc;

    localparam int DW = 76;
    localparam int PW = 8;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic [PW-1:0] m_parity;
    logic          m_ecc_fault;
    logic          bypass = 1'b0;
    logic          ecc_fault_detc_en = 1'b0;
    logic          fault_sticky;
    logic [CW-1:0] fault_cnt;
    logic          fault_clr = 1'b0;
    logic          inj_arm = 1'b0;
    logic [1:0]    inj_mode = 2'b00;
    logic          inj_armed;
    logic          inj_done;

    ecc_76_enc_fault_detc dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_parity         (m_parity),
        .m_ecc_fault      (m_ecc_fault),
        .bypass           (bypass),
        .ecc_fault_detc_en(ecc_fault_detc_en),
        .fault_sticky     (fault_sticky),
        .fault_cnt        (fault_cnt),
        .fault_clr        (fault_clr),
        .inj_arm          (inj_arm),
        .inj_mode         (inj_mode),
        .inj_armed        (inj_armed),
        .inj_done         (inj_done)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference code: syndrome = XOR of codeword positions of the set data
    // bits (positions skip powers of two), overall bit makes total parity even.
    function automatic logic [7:0] ref_par(input logic [DW-1:0] d);
        logic [31:0] syn;
        logic [6:0]  ham;
        int          k;
        syn = 0;
        k   = 0;
        for (int p = 1; k < DW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[k]) syn = syn ^ p;
                k++;
            end
        end
        ham = syn[6:0];
        return {(^d) ^ (^ham), ham};
    endfunction

    // Decoder view: returns {dbit_err, sbit_err}.
    function automatic logic [1:0] decode(input logic [DW-1:0] d, input logic [7:0] p);
        logic [7:0] r;
        logic [6:0] s;
        logic       ov;
        r  = ref_par(d);
        s  = r[6:0] ^ p[6:0];
        ov = (^d) ^ (^p);
        return {(s != 0) && !ov, ov};
    endfunction

    // ---------------- reference model ----------------
    logic          live = 1'b0;
    logic          force_on = 1'b0;
    logic [PW-1:0] force_val = '0;

    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic [PW-1:0] exp_par = '0;
    logic          exp_fault = 1'b0;
    logic          exp_sticky = 1'b0;
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_armed = 1'b0;
    logic [1:0]    exp_mode = 2'b00;
    logic          exp_done = 1'b0;
    logic          exp_new = 1'b0;
    logic          exp_byp = 1'b0;
    logic [1:0]    exp_inj = 2'b00;
    int            total_acc = 0;
    logic [DW-1:0] exp_q[$];

    logic          m_acc;
    logic [PW-1:0] m_ipar;
    logic          m_flt;
    int            m_c;

    always @(posedge clk) begin
        if (rst) begin
            live       = 1'b1;
            exp_valid  = 1'b0;
            exp_fault  = 1'b0;
            exp_sticky = 1'b0;
            exp_cnt    = '0;
            exp_armed  = 1'b0;
            exp_done   = 1'b0;
            exp_new    = 1'b0;
            exp_q.delete();
        end else begin
            m_acc  = s_valid && (!exp_valid || m_ready);
            m_ipar = bypass ? 8'h00 : ref_par(s_data);
            m_flt  = m_acc && ecc_fault_detc_en && force_on && (force_val != m_ipar);
            exp_new  = m_acc;
            exp_done = m_acc && exp_armed;
            if (m_acc) begin
                exp_data  = s_data ^ (exp_armed ? ((exp_mode == 2'b01) ? 76'h1 : 76'h3) : 76'h0);
                exp_par   = m_ipar;
                exp_fault = m_flt;
                exp_byp   = bypass;
                exp_inj   = exp_armed ? exp_mode : 2'b00;
                exp_valid = 1'b1;
                exp_q.push_back(exp_data);
                total_acc++;
            end else if (m_ready) begin
                exp_valid = 1'b0;
            end
            if (fault_clr) exp_sticky = 1'b0;
            else if (m_flt) exp_sticky = 1'b1;
            m_c = fault_clr ? 0 : int'(exp_cnt);
            if (m_flt && m_c < 255) m_c++;
            exp_cnt = CW'(m_c);
            if (exp_armed) begin
                if (m_acc) exp_armed = 1'b0;
            end else if (inj_arm && (inj_mode == 2'b01 || inj_mode == 2'b10)) begin
                exp_armed = 1'b1;
                exp_mode  = inj_mode;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [DW-1:0] sb_front;

    always @(negedge clk) begin
        if (live) begin
            chk("m_valid", 128'(m_valid), 128'(exp_valid));
            chk("s_ready", 128'(s_ready), 128'(!exp_valid || m_ready));
            chk("inj_armed", 128'(inj_armed), 128'(exp_armed));
            chk("inj_done", 128'(inj_done), 128'(exp_done));
            chk("fault_sticky", 128'(fault_sticky), 128'(exp_sticky));
            chk("fault_cnt", 128'(fault_cnt), 128'(exp_cnt));
            if (exp_valid) begin
                chk("m_data", 128'(m_data), 128'(exp_data));
                chk("m_parity", 128'(m_parity), 128'(exp_par));
                chk("m_ecc_fault", 128'(m_ecc_fault), 128'(exp_fault));
                if (exp_new && !exp_byp) begin
                    chk("decode", 128'(decode(m_data, m_parity)),
                        128'((exp_inj == 2'b10) ? 2'b10 : (exp_inj == 2'b01) ? 2'b01 : 2'b00));
                end
                if (m_ready && !rst) begin
                    if (exp_q.size() == 0) begin
                        chk("order_queue_empty", 128'(1), 128'(0));
                    end else begin
                        sb_front = exp_q.pop_front();
                        chk("order", 128'(m_data), 128'(sb_front));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic arm(input logic [1:0] mode);
        inj_arm  = 1'b1;
        inj_mode = mode;
        cycle();
        inj_arm  = 1'b0;
    endtask

    logic [DW-1:0] fdata;
    int            cyc;
    int            acc_start;

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        // reset state
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_s_ready", 128'(s_ready), 128'(1));
        chk("rst_fault_cnt", 128'(fault_cnt), 128'(0));
        chk("rst_sticky", 128'(fault_sticky), 128'(0));
        chk("rst_inj_armed", 128'(inj_armed), 128'(0));
        chk("rst_inj_done", 128'(inj_done), 128'(0));

        // zero word
        m_ready = 1'b1;
        beat('0);
        chk("zero_valid", 128'(m_valid), 128'(1));
        chk("zero_data", 128'(m_data), 128'(0));
        chk("zero_parity", 128'(m_parity), 128'(8'h00));
        chk("zero_fault", 128'(m_ecc_fault), 128'(0));

        // hand-computed codewords pin the model and the DUT
        chk("model_par_1", 128'(ref_par(76'h1)), 128'(8'h83));
        chk("model_par_ff", 128'(ref_par(76'hFF)), 128'(8'h03));
        beat(76'h1);
        chk("par_1", 128'(m_parity), 128'(8'h83));
        beat(76'hFF);
        chk("par_ff", 128'(m_parity), 128'(8'h03));

        // single-bit injection
        arm(2'b01);
        chk("single_armed", 128'(inj_armed), 128'(1));
        beat(76'hFF);
        chk("single_data", 128'(m_data), 128'(76'hFE));
        chk("single_parity", 128'(m_parity), 128'(8'h03));
        chk("single_sbit", 128'(decode(m_data, m_parity)), 128'(2'b01));
        chk("single_done", 128'(inj_done), 128'(1));
        chk("single_disarmed", 128'(inj_armed), 128'(0));
        beat(76'hFF);
        chk("single_next_clean", 128'(m_data), 128'(76'hFF));
        chk("single_done_pulse", 128'(inj_done), 128'(0));

        // double-bit injection; second arm while armed is ignored
        arm(2'b10);
        arm(2'b01);
        beat(76'hFF);
        chk("double_data", 128'(m_data), 128'(76'hFC));
        chk("double_dbit", 128'(decode(m_data, m_parity)), 128'(2'b10));
        beat(76'hFF);
        chk("double_next_clean", 128'(m_data), 128'(76'hFF));
        chk("double_no_done", 128'(inj_done), 128'(0));

        // lockstep fault via forced instance-1 parity
        ecc_fault_detc_en = 1'b1;
        force_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fdata     = 76'(64'h0123_4567_89AB_CDEF * (i + 1));
            force_val = ref_par(fdata) ^ 8'h01;
            force dut.enc1_parity = force_val;
            beat(fdata);
            chk("lockstep_fault", 128'(m_ecc_fault), 128'(1));
        end
        chk("lockstep_cnt3", 128'(fault_cnt), 128'(3));
        chk("lockstep_sticky", 128'(fault_sticky), 128'(1));
        fault_clr = 1'b1;
        cycle();
        fault_clr = 1'b0;
        chk("clr_cnt", 128'(fault_cnt), 128'(0));
        chk("clr_sticky", 128'(fault_sticky), 128'(0));
        ecc_fault_detc_en = 1'b0;
        beat(fdata);
        chk("en0_no_fault", 128'(m_ecc_fault), 128'(0));
        chk("en0_cnt", 128'(fault_cnt), 128'(0));

        // clear coincident with a faulty accept
        ecc_fault_detc_en = 1'b1;
        beat(fdata);
        fault_clr = 1'b1;
        beat(fdata);
        fault_clr = 1'b0;
        chk("clr_coinc_cnt", 128'(fault_cnt), 128'(1));
        chk("clr_coinc_sticky", 128'(fault_sticky), 128'(0));

        // saturation
        s_valid = 1'b1;
        s_data  = fdata;
        repeat (260) cycle();
        s_valid = 1'b0;
        chk("cnt_saturate", 128'(fault_cnt), 128'(8'hFF));
        release dut.enc1_parity;
        force_on = 1'b0;
        ecc_fault_detc_en = 1'b0;

        // reset while a beat is stalled and an injection is pending
        m_ready = 1'b0;
        beat(76'hABC);
        arm(2'b01);
        chk("stall_held", 128'(m_valid), 128'(1));
        rst = 1'b1;
        cycle();
        chk("midrst_m_valid", 128'(m_valid), 128'(0));
        chk("midrst_cnt", 128'(fault_cnt), 128'(0));
        chk("midrst_armed", 128'(inj_armed), 128'(0));
        rst = 1'b0;
        chk("midrst_s_ready", 128'(s_ready), 128'(1));
        m_ready = 1'b1;
        cycle();

        // randomized traffic with stalls
        acc_start = total_acc;
        cyc = 0;
        while ((total_acc - acc_start) < 500 && cyc < 8000) begin
            s_valid           = ($urandom_range(0, 3) != 0);
            s_data            = 76'({$urandom(), $urandom(), $urandom()});
            m_ready           = ($urandom_range(0, 3) != 0);
            bypass            = ($urandom_range(0, 9) == 0);
            ecc_fault_detc_en = $urandom_range(0, 1) == 1;
            inj_arm           = ($urandom_range(0, 15) == 0);
            inj_mode          = 2'($urandom_range(0, 3));
            fault_clr         = ($urandom_range(0, 31) == 0);
            cycle();
            cyc++;
        end
        chk("random_budget", 128'((total_acc - acc_start) >= 500), 128'(1));
        s_valid   = 1'b0;
        inj_arm   = 1'b0;
        fault_clr = 1'b0;
        bypass    = 1'b0;
        m_ready   = 1'b1;
        repeat (3) cycle();
        chk("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_76_enc_fault_detc.md
ECC_76_ENC_FAULT_DETC -- requirements
Module: ecc_76_enc_fault_detc

Interface
REQ-001 Parameter DATA_WIDTH, default 76, data bits per beat.
REQ-002 Parameter PARITY_WIDTH, default 8, SECDED check bits (7 Hamming + 1 overall).
REQ-003 Parameter CNT_WIDTH, default 8, fault counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_valid  input  1  upstream beat valid.
REQ-007 s_ready  output  1  block can accept a beat.
REQ-008 s_data  input  DATA_WIDTH  raw write data.
REQ-009 m_valid  output  1  encoded beat valid.
REQ-010 m_ready  input  1  downstream accepts.
REQ-011 m_data  output  DATA_WIDTH  data, after optional error injection.
REQ-012 m_parity  output  PARITY_WIDTH  check bits.
REQ-013 m_ecc_fault  output  1  lockstep mismatch flag for the current m_ beat.
REQ-014 bypass  input  1  parity generation disabled; m_parity forced 0.
REQ-015 ecc_fault_detc_en  input  1  lockstep comparison enable.
REQ-016 fault_sticky  output  1  set on any detected fault, held until fault_clr.
REQ-017 fault_cnt  output  CNT_WIDTH  count of faulty beats, saturating.
REQ-018 fault_clr  input  1  clears fault_sticky and fault_cnt.
REQ-019 inj_arm  input  1  pulse: arm one-shot error injection.
REQ-020 inj_mode  input  2  00 none, 01 single (flip data bit 0), 10 double (flip bits 0,1), 11 treated as 00.
REQ-021 inj_armed  output  1  injection pending.
REQ-022 inj_done  output  1  one-cycle pulse when injection applied.

Function
REQ-023 Parity SHALL be the exact check-bit function of the team's ecc_76_cal decoder (bypass=0), so every non-injected beat decodes with sbit_err=dbit_err=0.
REQ-024 Handshake: beat accepted when s_valid & s_ready; s_ready = ~m_valid | m_ready (1-deep output register, full throughput, no combinational s_valid->m_valid path).
REQ-025 Latency: accepted beat appears on m_* the next cycle; m_* SHALL hold stable while m_valid & ~m_ready.
REQ-026 Two identical encoder instances compute parity from s_data; m_parity SHALL come from instance 0.
REQ-027 Mismatch on accept with ecc_fault_detc_en=1: m_ecc_fault=1 for that beat, fault_sticky set, fault_cnt +1 saturating at all-ones; en=0 -> no fault reported.
REQ-028 fault_clr coincident with a faulty accept: clear wins for the sticky bit; fault_cnt SHALL become 1 (increment applied after clear).
REQ-029 bypass=1: m_parity=0, comparison still performed on instance outputs (both forced 0 -> no fault).
REQ-030 Injection FSM states IDLE, ARMED: IDLE->ARMED on inj_arm with inj_mode in {01,10}; ARMED->IDLE on next accepted beat, applying the flip to that beat's m_data only (parity computed on unflipped data), inj_done pulses the cycle m_valid rises with that beat.
REQ-031 inj_arm while ARMED ignored; inj_arm in the same cycle as an accept arms for the following beat; inj_mode sampled at arm time.
REQ-032 inj_armed = (state==ARMED).

Reset
REQ-033 rst SHALL set m_valid=0, m_ecc_fault=0, fault_sticky=0, fault_cnt=0, FSM=IDLE, inj_done=0; m_data/m_parity need no reset.
REQ-034 rst mid-transfer SHALL drop the held beat; s_ready=1 the first cycle after rst deasserts.

Structure
REQ-035 Shared package holds DATA_WIDTH/PARITY_WIDTH defaults, inj_mode encodings, FSM state encoding.
REQ-036 One sub-module ecc_76_enc (combinational parity generator, bypass input), instantiated twice; both instances SHALL carry keep/dont-touch so synthesis does not merge them.

Verification
REQ-037 s_data=0, bypass=0, m_ready=1 -> next cycle m_valid=1, m_data=0, m_parity=0x00, m_ecc_fault=0.
REQ-038 500 random beats, random m_ready stalls -> no drop/duplicate, order kept, each codeword decodes clean in ecc_76_cal.
REQ-039 inj_arm with inj_mode=01, then beat 0x0_0000_0000_0000_00FF -> m_data=...00FE, decoder sbit_err=1; next beat unflipped; inj_done one pulse.
REQ-040 inj_mode=10 -> decoder dbit_err=1; inj_arm while ARMED -> exactly one beat corrupted.
REQ-041 Force instance-1 parity bit 0 inverted, en=1, 3 beats -> m_ecc_fault=1 each, fault_cnt=3, fault_sticky=1; fault_clr -> 0; en=0 -> no fault.
REQ-042 Assert rst while m_valid=1 and m_ready=0 -> m_valid=0 next cycle, fault_cnt=0, inj_armed=0.
